// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: decouples IF from decode, up to two entries in/out per cycle.
// Optional performance counters are enabled with `define IFQ_PERF_CNT_EN.
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef BP_GHR_BITS
`define BP_GHR_BITS 8
`endif
`ifndef IF_BATCH_SIZE
`define IF_BATCH_SIZE 2
`endif

module inst_fetch_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic [`INST_ADDR_WIDTH-1:0] in_inst_addr_0,
  input  logic [`INST_ADDR_WIDTH-1:0] in_inst_addr_1,
  input  logic [`INST_WIDTH-1:0]      in_inst_0,
  input  logic [`INST_WIDTH-1:0]      in_inst_1,
  input  logic [`IF_BATCH_SIZE-1:0]   in_inst_valid,
  input  logic                        in_pred_taken_0,
  input  logic                        in_pred_taken_1,
  input  logic [`INST_ADDR_WIDTH-1:0] in_pred_target_0,
  input  logic [`INST_ADDR_WIDTH-1:0] in_pred_target_1,
  input  logic [`BP_GHR_BITS-1:0]     in_pred_hist_0,
  input  logic [`BP_GHR_BITS-1:0]     in_pred_hist_1,
  output logic                        out_fetch_stall,
  input  logic                        dec_ready,
  output logic [`INST_ADDR_WIDTH-1:0] out_inst_addr_0,
  output logic [`INST_ADDR_WIDTH-1:0] out_inst_addr_1,
  output logic [`INST_WIDTH-1:0]      out_inst_0,
  output logic [`INST_WIDTH-1:0]      out_inst_1,
  output logic                        out_pred_taken_0,
  output logic                        out_pred_taken_1,
  output logic [`INST_ADDR_WIDTH-1:0] out_pred_target_0,
  output logic [`INST_ADDR_WIDTH-1:0] out_pred_target_1,
  output logic [`BP_GHR_BITS-1:0]     out_pred_hist_0,
  output logic [`BP_GHR_BITS-1:0]     out_pred_hist_1,
  output logic [`IF_BATCH_SIZE-1:0]   out_inst_valid,
`ifdef IFQ_PERF_CNT_EN
  output logic                        out_overflow,
  output logic [31:0]                 out_stall_cycles,
  output logic [31:0]                 out_empty_cycles
`else
  output logic                        out_overflow
`endif
);

  localparam int AW = `INST_ADDR_WIDTH;
  localparam int IW = `INST_WIDTH;
  localparam int HW = `BP_GHR_BITS;
  localparam int EW = AW + IW + 1 + AW + HW;
  localparam logic [PTR_W:0]   CNT_ZERO  = '0;
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   STALL_TH  = (PTR_W+1)'(DEPTH - 4);
  localparam logic [PTR_W+1:0] SUM_DEPTH = (PTR_W+2)'(DEPTH);

  logic [EW-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             stall_q, stall_d;
  logic             overflow_q, overflow_d;

  logic [1:0]       enq_n, deq_n;
  logic [PTR_W+1:0] count_sum;
  logic             ovf;
  logic [PTR_W-1:0] head_p1, tail_p1;
  logic [EW-1:0]    slot0_entry, slot1_entry, rd0_entry, rd1_entry;
  logic             wr0_en, wr1_en;
  logic [EW-1:0]    wr0_data, wr1_data;

  assign slot0_entry = {in_inst_addr_0, in_inst_0, in_pred_taken_0, in_pred_target_0, in_pred_hist_0};
  assign slot1_entry = {in_inst_addr_1, in_inst_1, in_pred_taken_1, in_pred_target_1, in_pred_hist_1};
  assign head_p1     = head_q + PTR_W'(1);
  assign tail_p1     = tail_q + PTR_W'(1);
  assign rd0_entry   = mem_q[head_q];
  assign rd1_entry   = mem_q[head_p1];

  assign {out_inst_addr_0, out_inst_0, out_pred_taken_0, out_pred_target_0, out_pred_hist_0} = rd0_entry;
  assign {out_inst_addr_1, out_inst_1, out_pred_taken_1, out_pred_target_1, out_pred_hist_1} = rd1_entry;
  assign out_fetch_stall = stall_q;
  assign out_overflow    = overflow_q;

  // Handshake: every slot set in out_inst_valid is consumed on a cycle where
  // dec_ready=1; IF is never told "no" per batch, it only sees the registered stall.
  always_comb begin
    out_inst_valid = 2'b00;
    if (count_q > CNT_ONE)       out_inst_valid = 2'b11;
    else if (count_q == CNT_ONE) out_inst_valid = 2'b01;

    enq_n = {1'b0, in_inst_valid[0]} + {1'b0, in_inst_valid[1]};
    deq_n = 2'b00;
    if (dec_ready) deq_n = {1'b0, out_inst_valid[0]} + {1'b0, out_inst_valid[1]};

    count_sum = {1'b0, count_q} - {{PTR_W{1'b0}}, deq_n} + {{PTR_W{1'b0}}, enq_n};
    ovf       = count_sum > SUM_DEPTH;

    // Compaction: the first valid slot always lands at tail.
    wr0_en   = 1'b0;
    wr1_en   = 1'b0;
    wr0_data = slot0_entry;
    wr1_data = slot1_entry;
    if (!flush && !ovf) begin
      wr0_en = in_inst_valid[0] | in_inst_valid[1];
      wr1_en = in_inst_valid[0] & in_inst_valid[1];
      if (!in_inst_valid[0]) wr0_data = slot1_entry;
    end

    head_d     = head_q + PTR_W'(deq_n);
    tail_d     = ovf ? tail_q : tail_q + PTR_W'(enq_n);
    count_d    = ovf ? count_q - {{(PTR_W-1){1'b0}}, deq_n} : count_sum[PTR_W:0];
    stall_d    = count_d > STALL_TH;
    overflow_d = overflow_q | ovf;
    if (flush) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      stall_d    = 1'b0;
      overflow_d = overflow_q;
    end
  end

  // Storage is intentionally not reset; the valid mask gates its use.
  always_ff @(posedge clk) begin
    if (wr0_en) mem_q[tail_q]  <= wr0_data;
    if (wr1_en) mem_q[tail_p1] <= wr1_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      stall_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      stall_q    <= stall_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef IFQ_PERF_CNT_EN
  logic [31:0] stall_cyc_q, empty_cyc_q;
  assign out_stall_cycles = stall_cyc_q;
  assign out_empty_cycles = empty_cyc_q;

  // Counters saturate and ignore flush; only rst_n clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cyc_q <= '0;
      empty_cyc_q <= '0;
    end else begin
      if (stall_q && stall_cyc_q != 32'hFFFF_FFFF) stall_cyc_q <= stall_cyc_q + 32'd1;
      if (count_q == CNT_ZERO && !flush && empty_cyc_q != 32'hFFFF_FFFF)
        empty_cyc_q <= empty_cyc_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: scoreboard of expected entries popped by a
// negedge monitor whenever decode consumes, plus hand-computed status checks.
module tb_inst_fetch_queue;

  localparam int W = 32 + 32 + 1 + 32 + 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] in_inst_addr_0 = '0, in_inst_addr_1 = '0;
  logic [31:0] in_inst_0 = '0, in_inst_1 = '0;
  logic [1:0]  in_inst_valid = '0;
  logic        in_pred_taken_0 = 1'b0, in_pred_taken_1 = 1'b0;
  logic [31:0] in_pred_target_0 = '0, in_pred_target_1 = '0;
  logic [7:0]  in_pred_hist_0 = '0, in_pred_hist_1 = '0;
  logic        dec_ready = 1'b0;
  logic        out_fetch_stall;
  logic [31:0] out_inst_addr_0, out_inst_addr_1, out_inst_0, out_inst_1;
  logic        out_pred_taken_0, out_pred_taken_1;
  logic [31:0] out_pred_target_0, out_pred_target_1;
  logic [7:0]  out_pred_hist_0, out_pred_hist_1;
  logic [1:0]  out_inst_valid;
  logic        out_overflow;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  inst_fetch_queue dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_inst_addr_0(in_inst_addr_0), .in_inst_addr_1(in_inst_addr_1),
    .in_inst_0(in_inst_0), .in_inst_1(in_inst_1), .in_inst_valid(in_inst_valid),
    .in_pred_taken_0(in_pred_taken_0), .in_pred_taken_1(in_pred_taken_1),
    .in_pred_target_0(in_pred_target_0), .in_pred_target_1(in_pred_target_1),
    .in_pred_hist_0(in_pred_hist_0), .in_pred_hist_1(in_pred_hist_1),
    .out_fetch_stall(out_fetch_stall), .dec_ready(dec_ready),
    .out_inst_addr_0(out_inst_addr_0), .out_inst_addr_1(out_inst_addr_1),
    .out_inst_0(out_inst_0), .out_inst_1(out_inst_1),
    .out_pred_taken_0(out_pred_taken_0), .out_pred_taken_1(out_pred_taken_1),
    .out_pred_target_0(out_pred_target_0), .out_pred_target_1(out_pred_target_1),
    .out_pred_hist_0(out_pred_hist_0), .out_pred_hist_1(out_pred_hist_1),
    .out_inst_valid(out_inst_valid), .out_overflow(out_overflow)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Entry fields derived from the pc: inst = pc^DEAD0000, taken = pc[4],
  // target = pc+0x30, hist = pc[9:2].
  function automatic logic [W-1:0] mk(input logic [31:0] pc);
    logic [31:0] tgt;
    tgt = pc + 32'h30;
    return {pc, pc ^ 32'hDEAD_0000, pc[4], tgt, pc[9:2]};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver: one cycle of stimulus, inputs return to idle just after the edge.
  task automatic issue(input logic [1:0] mask, input logic [31:0] pc0, input logic [31:0] pc1,
                       input logic dr, input logic fl, input logic push);
    logic [W-1:0] e0, e1;
    e0 = mk(pc0);
    e1 = mk(pc1);
    {in_inst_addr_0, in_inst_0, in_pred_taken_0, in_pred_target_0, in_pred_hist_0} = e0;
    {in_inst_addr_1, in_inst_1, in_pred_taken_1, in_pred_target_1, in_pred_hist_1} = e1;
    in_inst_valid = mask;
    dec_ready     = dr;
    flush         = fl;
    if (fl) exp_q.delete();
    if (push && mask[0]) exp_q.push_back(e0);
    if (push && mask[1]) exp_q.push_back(e1);
    @(posedge clk);
    #1;
    in_inst_valid = 2'b00;
    dec_ready     = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic idle(input logic dr, input int n);
    for (int k = 0; k < n; k++) issue(2'b00, 32'h0, 32'h0, dr, 1'b0, 1'b0);
  endtask

  // Monitor / scoreboard: compares every slot decode consumes.
  always @(negedge clk) begin
    if (rst_n && !flush && dec_ready) begin
      if (out_inst_valid[0]) begin
        if (exp_q.size() == 0) check("sb_slot0_unexpected", 128'(out_inst_addr_0), 128'hFFFF);
        else check("sb_slot0", 128'({out_inst_addr_0, out_inst_0, out_pred_taken_0,
                                     out_pred_target_0, out_pred_hist_0}), 128'(exp_q.pop_front()));
      end
      if (out_inst_valid[1]) begin
        if (exp_q.size() == 0) check("sb_slot1_unexpected", 128'(out_inst_addr_1), 128'hFFFF);
        else check("sb_slot1", 128'({out_inst_addr_1, out_inst_1, out_pred_taken_1,
                                     out_pred_target_1, out_pred_hist_1}), 128'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 128'(out_inst_valid), 128'h0);
    check("rst_stall", 128'(out_fetch_stall), 128'h0);
    check("rst_overflow", 128'(out_overflow), 128'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Pair presented the cycle after the write
    issue(2'b11, 32'h0, 32'h4, 1'b0, 1'b0, 1'b1);
    check("pair_valid", 128'(out_inst_valid), 128'h3);
    check("pair_addr0", 128'(out_inst_addr_0), 128'h0);
    check("pair_addr1", 128'(out_inst_addr_1), 128'h4);
    idle(1'b1, 1);
    check("pair_drained", 128'(out_inst_valid), 128'h0);

    // Single entry with a taken prediction
    issue(2'b01, 32'h10, 32'h0, 1'b1, 1'b0, 1'b1);
    check("single_valid", 128'(out_inst_valid), 128'h1);
    check("single_taken", 128'(out_pred_taken_0), 128'h1);
    check("single_target", 128'(out_pred_target_0), 128'h40);
    idle(1'b1, 1);
    check("single_drained", 128'(out_inst_valid), 128'h0);

    // Mask 2'b10 compacts slot1 to the head
    issue(2'b10, 32'h0, 32'hC, 1'b0, 1'b0, 1'b1);
    check("compact_valid", 128'(out_inst_valid), 128'h1);
    check("compact_addr0", 128'(out_inst_addr_0), 128'hC);
    idle(1'b1, 1);

    // Fill to DEPTH with decode stalled
    issue(2'b11, 32'h20, 32'h24, 1'b0, 1'b0, 1'b1);
    check("fill2_stall", 128'(out_fetch_stall), 128'h0);
    issue(2'b11, 32'h28, 32'h2C, 1'b0, 1'b0, 1'b1);
    check("fill4_stall", 128'(out_fetch_stall), 128'h0);
    issue(2'b11, 32'h30, 32'h34, 1'b0, 1'b0, 1'b1);
    check("fill6_stall", 128'(out_fetch_stall), 128'h1);
    issue(2'b11, 32'h38, 32'h3C, 1'b0, 1'b0, 1'b1);
    check("fill8_stall", 128'(out_fetch_stall), 128'h1);
    check("fill8_valid", 128'(out_inst_valid), 128'h3);
    check("fill8_overflow", 128'(out_overflow), 128'h0);
    idle(1'b1, 4);
    check("fill_drained_valid", 128'(out_inst_valid), 128'h0);
    check("fill_drained_stall", 128'(out_fetch_stall), 128'h0);

    // Streaming across pointer wrap
    for (int i = 0; i < 20; i++) begin
      issue(2'b11, 32'h100 + 32'(i * 8), 32'h104 + 32'(i * 8), 1'b1, 1'b0, 1'b1);
      check("wrap_stall", 128'(out_fetch_stall), 128'h0);
    end
    idle(1'b1, 1);
    check("wrap_drained", 128'(out_inst_valid), 128'h0);

    // Flush at count=5 with a same-cycle batch
    issue(2'b11, 32'h180, 32'h184, 1'b0, 1'b0, 1'b1);
    issue(2'b11, 32'h188, 32'h18C, 1'b0, 1'b0, 1'b1);
    issue(2'b01, 32'h190, 32'h0, 1'b0, 1'b0, 1'b1);
    check("cnt5_stall", 128'(out_fetch_stall), 128'h1);
    issue(2'b11, 32'h1A0, 32'h1A4, 1'b1, 1'b1, 1'b0);
    check("flush_valid", 128'(out_inst_valid), 128'h0);
    check("flush_stall", 128'(out_fetch_stall), 128'h0);
    issue(2'b11, 32'h200, 32'h204, 1'b0, 1'b0, 1'b1);
    check("post_flush_valid", 128'(out_inst_valid), 128'h3);
    check("post_flush_addr0", 128'(out_inst_addr_0), 128'h200);
    idle(1'b1, 1);

    // Overflow: three batches forced while full
    for (int i = 0; i < 4; i++) issue(2'b11, 32'h300 + 32'(i * 8), 32'h304 + 32'(i * 8), 1'b0, 1'b0, 1'b1);
    check("ovf_pre", 128'(out_overflow), 128'h0);
    issue(2'b11, 32'h400, 32'h404, 1'b0, 1'b0, 1'b0);
    check("ovf_set", 128'(out_overflow), 128'h1);
    check("ovf_head_kept", 128'(out_inst_addr_0), 128'h300);
    issue(2'b11, 32'h408, 32'h40C, 1'b0, 1'b0, 1'b0);
    issue(2'b11, 32'h410, 32'h414, 1'b0, 1'b0, 1'b0);
    check("ovf_valid", 128'(out_inst_valid), 128'h3);
    idle(1'b1, 4);
    check("ovf_drained", 128'(out_inst_valid), 128'h0);
    check("ovf_sticky", 128'(out_overflow), 128'h1);

    // Reset in the middle of operation
    issue(2'b11, 32'h500, 32'h504, 1'b0, 1'b0, 1'b0);
    check("mid_valid", 128'(out_inst_valid), 128'h3);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 128'(out_inst_valid), 128'h0);
    check("mid_rst_overflow", 128'(out_overflow), 128'h0);
    check("mid_rst_stall", 128'(out_fetch_stall), 128'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1'b1, 2);
    check("final_valid", 128'(out_inst_valid), 128'h0);
    check("sb_leftover", 128'(exp_q.size()), 128'h0);

    // Report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
